// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// WIDTH and ADDR_BITS are fixed here, and every fetch file uses them.
// HALT_WORD is only acted on when the design is built with FETCH_HALT_EN defined.
package fetch_pkg;

    localparam int WIDTH     = 9;
    localparam int ADDR_BITS = 5;

    typedef logic [ADDR_BITS-1:0] pc_t;
    typedef logic [WIDTH-1:0]     instr_t;

    typedef struct packed {
        instr_t word;
        pc_t    pc;
    } fetch_entry_t;

    localparam instr_t       HALT_WORD  = {WIDTH{1'b1}};
    localparam pc_t          PC_ZERO    = {ADDR_BITS{1'b0}};
    localparam instr_t       INSTR_ZERO = {WIDTH{1'b0}};
    localparam fetch_entry_t ENTRY_ZERO = '{word: INSTR_ZERO, pc: PC_ZERO};

    // Sequential PC step. The ROM is exactly 2**ADDR_BITS deep, so the
    // natural modulo wrap of the adder is the intended behaviour.
    function automatic pc_t pc_next(input pc_t pc);
        return pc + {{(ADDR_BITS-1){1'b0}}, 1'b1};
    endfunction

    // Words that will be held or in flight after this edge if no new fetch
    // is issued. A new fetch is allowed only while this stays below 2, so a
    // returning word always finds a free buffer slot.
    function automatic logic [2:0] pending_after(input logic [1:0] occ,
                                                 input logic       inflight,
                                                 input logic       pop);
        return {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    endfunction

endpackage

// File: rtl/fetch_buf.sv
// Two-entry FIFO that holds fetched words and their PCs for decode.
// The head comes straight from storage flops, so rom_data never reaches
// the decode outputs through combinational logic.
module fetch_buf
    import fetch_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t push_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic [1:0]   occ
);

    logic [1:0]   count_q, count_d;
    logic         rd_q, rd_d;
    logic         wr_q, wr_d;
    fetch_entry_t ent0_q, ent0_d;
    fetch_entry_t ent1_q, ent1_d;
    logic         pop_ok_s;
    logic         push_ok_s;

    // Qualify requests so an empty pop or an overflowing push can never corrupt pointers
    always_comb begin
        pop_ok_s  = 1'b0;
        push_ok_s = 1'b0;
        if (pop && (count_q != 2'd0)) begin
            pop_ok_s = 1'b1;
        end else begin
            pop_ok_s = 1'b0;
        end
        if (push && ((count_q != 2'd2) || pop_ok_s)) begin
            push_ok_s = 1'b1;
        end else begin
            push_ok_s = 1'b0;
        end
    end

    // Next-state for storage, pointers and count; flush empties the FIFO
    always_comb begin
        count_d = count_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        ent0_d  = ent0_q;
        ent1_d  = ent1_q;
        if (flush) begin
            count_d = 2'd0;
            rd_d    = 1'b0;
            wr_d    = 1'b0;
        end else begin
            if (push_ok_s) begin
                if (wr_q) begin
                    ent1_d = push_entry;
                end else begin
                    ent0_d = push_entry;
                end
                wr_d = ~wr_q;
            end else begin
                wr_d = wr_q;
            end
            if (pop_ok_s) begin
                rd_d = ~rd_q;
            end else begin
                rd_d = rd_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            ent0_q  <= ENTRY_ZERO;
            ent1_q  <= ENTRY_ZERO;
        end else begin
            count_q <= count_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            ent0_q  <= ent0_d;
            ent1_q  <= ent1_d;
        end
    end

    // Head selection from the flopped entries
    always_comb begin
        if (rd_q) begin
            head = ent1_q;
        end else begin
            head = ent0_q;
        end
    end

    assign occ = count_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage in front of a synchronous-read instruction ROM.
// It owns the fetch PC, tracks the single in-flight ROM read, and buffers
// returned words in a 2-entry FIFO that feeds decode over valid/ready.
// Optional macro FETCH_HALT_EN: when defined, a captured HALT_WORD stops
// further fetching until a redirect or a reset. The halt word itself is
// still delivered to decode.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter pc_t RESET_PC = PC_ZERO
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [WIDTH-1:0]     rom_data,
    input  logic                 redirect,
    input  logic [ADDR_BITS-1:0] redirect_pc,
    output logic [WIDTH-1:0]     instr,
    output logic [ADDR_BITS-1:0] instr_pc,
    output logic                 instr_valid,
    input  logic                 instr_ready
);

    pc_t          fpc_q, fpc_d;
    logic         inflight_q, inflight_d;
    pc_t          inflight_pc_q, inflight_pc_d;
    logic         halted_q, halted_d;

    logic [1:0]   occ_s;
    fetch_entry_t head_s;
    fetch_entry_t push_entry_s;
    logic         pop_s;
    logic         capture_s;
    logic         halt_cap_s;
    logic         issue_s;

    // Decode handshake and capture qualification; a redirect discards the returning word
    always_comb begin
        pop_s        = instr_valid && instr_ready;
        push_entry_s = '{word: rom_data, pc: inflight_pc_q};
        if (inflight_q && !redirect) begin
            capture_s = 1'b1;
        end else begin
            capture_s = 1'b0;
        end
    end

    // Halt-word detection on the word being captured this edge
    always_comb begin
`ifdef FETCH_HALT_EN
        if (capture_s && (rom_data == HALT_WORD)) begin
            halt_cap_s = 1'b1;
        end else begin
            halt_cap_s = 1'b0;
        end
`else
        halt_cap_s = 1'b0;
`endif
    end

    // Issue decision: only issue while the returning word is sure to have a free slot
    always_comb begin
        if (!redirect && !halted_q && !halt_cap_s &&
            (pending_after(occ_s, inflight_q, pop_s) < 3'd2)) begin
            issue_s = 1'b1;
        end else begin
            issue_s = 1'b0;
        end
    end

    // PC, in-flight and halt next-state; redirect takes priority over everything
    always_comb begin
        fpc_d         = fpc_q;
        inflight_d    = 1'b0;
        inflight_pc_d = inflight_pc_q;
        halted_d      = halted_q;
        if (redirect) begin
            fpc_d         = redirect_pc;
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
            halted_d      = 1'b0;
        end else if (issue_s) begin
            fpc_d         = pc_next(fpc_q);
            inflight_d    = 1'b1;
            inflight_pc_d = fpc_q;
            halted_d      = halted_q || halt_cap_s;
        end else begin
            fpc_d         = fpc_q;
            inflight_d    = 1'b0;
            inflight_pc_d = inflight_pc_q;
            halted_d      = halted_q || halt_cap_s;
        end
    end

    // Fetch-control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fpc_q         <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= PC_ZERO;
            halted_q      <= 1'b0;
        end else begin
            fpc_q         <= fpc_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            halted_q      <= halted_d;
        end
    end

    fetch_buf u_buf (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (capture_s),
        .push_entry (push_entry_s),
        .pop        (pop_s),
        .flush      (redirect),
        .head       (head_s),
        .occ        (occ_s)
    );

    assign rom_addr    = fpc_q;
    assign instr       = head_s.word;
    assign instr_pc    = head_s.pc;
    assign instr_valid = (occ_s != 2'd0);

endmodule
